// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
//
// Stereo sample FIFO with priming. Each entry is one left/right pair of
// 32-bit words. A 2^DEPTH_LOG2 entry circular buffer sits behind a show-ahead
// read port. The read port only starts presenting data after the buffer
// has filled to PRIME_LEVEL entries. It goes back to priming whenever it
// drains.
//
// Optional feature: define AUDIO_SAMPLE_FIFO_STATS_EN to build the underrun
// counter and the sticky overflow flag. Without the macro, both outputs are
// tied to zero and no counter logic is built.
//
// Handshakes:
//   write: an entry is accepted on a posedge where wr_valid=1, wr_ready=1
//          and flush=0. wr_valid while wr_ready=0 is a dropped write (the
//          producer is not back-pressured).
//   read : while fifo_ready=1 the head entry is on fifo_*_data. fifo_ack=1
//          on that cycle pops it. fifo_ack while fifo_ready=0 is an
//          underrun and pops nothing.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   flush               synchronous clear of contents and state
//   wr_valid/left/right producer side, audio in bits [31:16]
//   wr_ready            not full (registered state only)
//   fifo_left_data/right_data/fifo_ready/fifo_ack   consumer side
//   level               entry count 0..2^DEPTH_LOG2
//   underrun_cnt        saturating count of acks while not ready
//   overflow            sticky, a write was dropped because the FIFO was full
//   dbg_state           FSM state, 0 = PRIME, 1 = RUN
// ---------------------------------------------------------------------------
module audio_sample_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [31:0]           wr_left,
    input  logic [31:0]           wr_right,
    output logic                  wr_ready,
    output logic [31:0]           fifo_left_data,
    output logic [31:0]           fifo_right_data,
    output logic                  fifo_ready,
    input  logic                  fifo_ack,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           underrun_cnt,
    output logic                  overflow,
    output logic                  dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   PRIME_LVL = (DEPTH_LOG2+1)'(PRIME_LEVEL);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    level_q, level_d;
    logic                   ready_q, ready_d;
    logic                   push, pop;

    // Storage is not reset. Stale contents are never presented, because
    // fifo_ready only rises over written entries.
    logic [63:0]            mem_q [DEPTH];

    assign wr_ready        = (level_q < DEPTH_LVL);
    assign level           = level_q;
    assign fifo_ready      = ready_q;
    assign dbg_state       = (state_q == ST_RUN);
    assign fifo_left_data  = ready_q ? mem_q[rd_ptr_q][63:32] : 32'd0;
    assign fifo_right_data = ready_q ? mem_q[rd_ptr_q][31:0]  : 32'd0;

    always_comb begin
        push     = wr_valid && wr_ready && !flush;
        pop      = fifo_ack && ready_q && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        state_d  = state_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        if (push && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;

        case (state_q)
            // The threshold is checked on registered level, so RUN begins
            // the cycle after the fill reaches PRIME_LEVEL.
            ST_PRIME: if (level_q >= PRIME_LVL) state_d = ST_RUN;
            // Popping the last entry re-primes even if a write lands in the
            // same cycle. The new entry then waits for a full refill.
            ST_RUN:   if ((pop && level_q == LVL_ONE) || level_q == '0)
                          state_d = ST_PRIME;
            default:  state_d = ST_PRIME;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            state_d  = ST_PRIME;
        end

        // fifo_ready is registered, but it always equals
        // (state == RUN && level != 0) on the registered values.
        ready_d = (state_d == ST_RUN) && (level_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_PRIME;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_left, wr_right};
    end

`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
    logic [15:0] underrun_q;
    logic        overflow_q;

    // Both statistics survive flush. Only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) overflow_q <= 1'b1;
            if (fifo_ack && !ready_q && underrun_q != 16'hFFFF)
                underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
    assign overflow     = overflow_q;
`else
    assign underrun_cnt = 16'd0;
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;

`ifdef AUDIO_SAMPLE_FIFO_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        wr_valid;
    logic [31:0] wr_left;
    logic [31:0] wr_right;
    logic        wr_ready;
    logic [31:0] fifo_left_data;
    logic [31:0] fifo_right_data;
    logic        fifo_ready;
    logic        fifo_ack;
    logic [4:0]  level;
    logic [15:0] underrun_cnt;
    logic        overflow;
    logic        dbg_state;

    always #5 clk = ~clk;

    audio_sample_fifo #(.DEPTH_LOG2(4), .PRIME_LEVEL(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .wr_valid        (wr_valid),
        .wr_left         (wr_left),
        .wr_right        (wr_right),
        .wr_ready        (wr_ready),
        .fifo_left_data  (fifo_left_data),
        .fifo_right_data (fifo_right_data),
        .fifo_ready      (fifo_ready),
        .fifo_ack        (fifo_ack),
        .level           (level),
        .underrun_cnt    (underrun_cnt),
        .overflow        (overflow),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          check_cnt = 0;
    int          err_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        check_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] lval(input logic [31:0] n);
        return n << 16;
    endfunction

    function automatic logic [31:0] rval(input logic [31:0] n);
        return ((n + 32'd1000) << 16) | 32'h0000_5A5A;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus. With do_ack set, the head is checked against the
    // scoreboard before the pop. accept says whether the write should land.
    task automatic step(input bit do_wr, input int n, input bit do_ack, input bit accept);
        logic [31:0] e;
        wr_valid = do_wr;
        wr_left  = lval(n);
        wr_right = rval(n);
        fifo_ack = do_ack;
        if (do_ack) begin
            check_eq("ack_ready", {31'd0, fifo_ready}, 32'd1);
            check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("pop_left", fifo_left_data, lval(e));
                check_eq("pop_right", fifo_right_data, rval(e));
            end
        end
        if (do_wr && accept) exp_q.push_back(n);
        tick();
        wr_valid = 1'b0;
        fifo_ack = 1'b0;
    endtask

    task automatic check_empty_outputs(input string tag);
        check_eq({tag, "_level"}, {27'd0, level}, 32'd0);
        check_eq({tag, "_rdy"}, {31'd0, fifo_ready}, 32'd0);
        check_eq({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
        check_eq({tag, "_left"}, fifo_left_data, 32'd0);
        check_eq({tag, "_right"}, fifo_right_data, 32'd0);
        check_eq({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n  = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_left  = '0;
        wr_right = '0;
        fifo_ack = 1'b0;
        tick();
        tick();
        check_empty_outputs("reset");
        check_eq("reset_underrun", {16'd0, underrun_cnt}, 32'd0);
        check_eq("reset_overflow", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Priming: 7 writes keep the output closed. The 8th opens it a
        // cycle later.
        for (int n = 1; n <= 7; n++) begin
            step(1'b1, n, 1'b0, 1'b1);
            check_eq("prime_rdy", {31'd0, fifo_ready}, 32'd0);
        end
        check_eq("prime_level7", {27'd0, level}, 32'd7);
        step(1'b1, 8, 1'b0, 1'b1);
        check_eq("prime_level8", {27'd0, level}, 32'd8);
        check_eq("prime_rdy8", {31'd0, fifo_ready}, 32'd0);
        tick();
        check_eq("run_rdy", {31'd0, fifo_ready}, 32'd1);
        check_eq("run_state", {31'd0, dbg_state}, 32'd1);
        check_eq("run_left1", fifo_left_data, lval(1));
        check_eq("run_right1", fifo_right_data, rval(1));

        // Fill to 16, then a 17th write with a same-cycle ack.
        for (int n = 9; n <= 16; n++) step(1'b1, n, 1'b0, 1'b1);
        check_eq("full_level", {27'd0, level}, 32'd16);
        check_eq("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        step(1'b1, 17, 1'b1, 1'b0);
        check_eq("ovf_level", {27'd0, level}, 32'd15);
        check_eq("ovf_flag", {31'd0, overflow}, {31'd0, STATS_EN});
        check_eq("ovf_wr_ready", {31'd0, wr_ready}, 32'd1);
        for (int i = 0; i < 15; i++) step(1'b0, 0, 1'b1, 1'b0);
        check_empty_outputs("drain1");

        // Three acks while priming are underruns and pop nothing.
        for (int i = 0; i < 3; i++) begin
            fifo_ack = 1'b1;
            tick();
            fifo_ack = 1'b0;
            tick();
        end
        check_eq("underrun3", {16'd0, underrun_cnt}, STATS_EN ? 32'd3 : 32'd0);
        check_empty_outputs("underrun");

        // RUN at level 1, then a pop plus a write: back to PRIME at level 1.
        for (int n = 101; n <= 108; n++) step(1'b1, n, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) step(1'b0, 0, 1'b1, 1'b0);
        check_eq("lvl1_level", {27'd0, level}, 32'd1);
        check_eq("lvl1_rdy", {31'd0, fifo_ready}, 32'd1);
        step(1'b1, 109, 1'b1, 1'b1);
        check_eq("reprime_level", {27'd0, level}, 32'd1);
        check_eq("reprime_rdy", {31'd0, fifo_ready}, 32'd0);
        check_eq("reprime_state", {31'd0, dbg_state}, 32'd0);
        check_eq("reprime_left", fifo_left_data, 32'd0);
        for (int n = 110; n <= 116; n++) begin
            step(1'b1, n, 1'b0, 1'b1);
            check_eq("reprime_hold", {31'd0, fifo_ready}, 32'd0);
        end
        check_eq("reprime_level8", {27'd0, level}, 32'd8);
        tick();
        check_eq("reprime_open", {31'd0, fifo_ready}, 32'd1);
        check_eq("reprime_head", fifo_left_data, lval(109));

        // Flush with a same-cycle write: the FIFO empties and the
        // statistics are kept.
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_left  = lval(999);
        wr_right = rval(999);
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        check_empty_outputs("flush");
        check_eq("flush_overflow", {31'd0, overflow}, {31'd0, STATS_EN});
        check_eq("flush_underrun", {16'd0, underrun_cnt}, STATS_EN ? 32'd3 : 32'd0);
        tick();
        check_eq("flush_level_hold", {27'd0, level}, 32'd0);

        // Streaming 40 entries: write every cycle, ack every cycle once open.
        for (int n = 301; n <= 309; n++) step(1'b1, n, 1'b0, 1'b1);
        check_eq("stream_rdy", {31'd0, fifo_ready}, 32'd1);
        for (int n = 310; n <= 340; n++) step(1'b1, n, 1'b1, 1'b1);
        check_eq("stream_level", {27'd0, level}, 32'd9);
        for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1, 1'b0);
        check_empty_outputs("stream_end");
        check_eq("stream_sb_empty", exp_q.size(), 32'd0);
        check_eq("stream_underrun", {16'd0, underrun_cnt}, STATS_EN ? 32'd3 : 32'd0);

        // Reset asserted between edges with 10 entries stored.
        for (int n = 401; n <= 410; n++) step(1'b1, n, 1'b0, 1'b1);
        tick();
        check_eq("pre_rst_level", {27'd0, level}, 32'd10);
        check_eq("pre_rst_rdy", {31'd0, fifo_ready}, 32'd1);
        check_eq("pre_rst_head", fifo_left_data, lval(401));
        #3;
        reset_n = 1'b0;
        #1;
        check_empty_outputs("async_rst");
        check_eq("async_rst_underrun", {16'd0, underrun_cnt}, 32'd0);
        check_eq("async_rst_overflow", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_empty_outputs("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
